fib_stack: RTL and testbench

- LIFO operand stack for the Fibonacci datapath.
- Holds intermediate Fibonacci terms pushed by the sequencer and returns them on pop with a registered read port.
- Keeps its own stack pointer and exports it on `sp`, so the sequencer and debug logic see depth directly.
- Detects overflow and underflow and reports them on a sticky error flag.

---
 rtl/fib_stack.sv | 122 ++++++++++++
 tb/tb_fib_stack.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fib_stack.sv
// fib_stack: LIFO operand stack for the Fibonacci datapath.
// Registered pop port, exported entry count, sticky overflow/underflow flag.
// Optional macro STACK_PEEK_EN adds a combinational `top` peek port.
//
// Command semantics (no handshake back-pressure): push/pop are sampled on every
// rising edge. push alone writes din when not full; pop alone returns the top
// entry on dout one cycle later with a single-cycle dout_valid pulse; push+pop
// together replaces the top (or bypasses din straight to dout when empty).
// Refused commands (push when full, pop when empty) set err, which only
// reset (clr=0) clears.
module fib_stack #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic [ADDR_W:0]   sp,
  output logic              empty,
  output logic              full,
  output logic              err
`ifdef STACK_PEEK_EN
  ,
  output logic [DATA_W-1:0] top
`endif
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] wr_idx;
  logic [ADDR_W-1:0] top_idx;
  logic              do_push;
  logic              do_pop;
  logic              do_replace;
  logic              do_bypass;
  logic              overflow;
  logic              underflow;

  assign empty = (sp == '0);
  assign full  = (sp == (ADDR_W+1)'(DEPTH));

  // Low address bits suffice: a write at sp only happens when not full, and
  // when full sp-1 wraps the low bits correctly to DEPTH-1.
  assign wr_idx  = sp[ADDR_W-1:0];
  assign top_idx = sp[ADDR_W-1:0] - ADDR_W'(1);

  // Decode the command into mutually exclusive actions.
  always_comb begin
    do_push    = 1'b0;
    do_pop     = 1'b0;
    do_replace = 1'b0;
    do_bypass  = 1'b0;
    overflow   = 1'b0;
    underflow  = 1'b0;
    if (push && pop) begin
      do_replace = !empty;
      do_bypass  = empty;
    end else if (push) begin
      do_push  = !full;
      overflow = full;
    end else if (pop) begin
      do_pop    = !empty;
      underflow = empty;
    end
  end

  // Storage writes; contents are don't-care after reset, so no reset here.
  always_ff @(posedge clk) begin
    if (clr) begin
      if (do_push) begin
        mem[wr_idx] <= din;
      end else if (do_replace) begin
        mem[top_idx] <= din;
      end
    end
  end

  // Stack pointer, read port, and sticky error flag.
  always_ff @(posedge clk) begin
    if (!clr) begin
      sp         <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      err        <= 1'b0;
    end else begin
      dout_valid <= 1'b0;
      if (do_push) begin
        sp <= sp + (ADDR_W+1)'(1);
      end else if (do_pop) begin
        sp         <= sp - (ADDR_W+1)'(1);
        dout       <= mem[top_idx];
        dout_valid <= 1'b1;
      end else if (do_replace) begin
        dout       <= mem[top_idx];
        dout_valid <= 1'b1;
      end else if (do_bypass) begin
        dout       <= din;
        dout_valid <= 1'b1;
      end
      if (overflow || underflow) begin
        err <= 1'b1;
      end
    end
  end

`ifdef STACK_PEEK_EN
  // Peek at the current top from registered state only.
  always_comb begin
    top = '0;
    if (!empty) begin
      top = mem[top_idx];
    end
  end
`endif

endmodule

// File: tb/tb_fib_stack.sv
// tb_fib_stack: directed plus randomized check of fib_stack against a
// queue-based LIFO model. Define STACK_PEEK_EN to also check the `top` port.
module tb_fib_stack;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk;
  logic              clr;
  logic              push;
  logic              pop;
  logic [DATA_W-1:0] din;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic [ADDR_W:0]   sp;
  logic              empty;
  logic              full;
  logic              err;
`ifdef STACK_PEEK_EN
  logic [DATA_W-1:0] top;
`endif

  fib_stack #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .clr        (clr),
    .push       (push),
    .pop        (pop),
    .din        (din),
    .dout       (dout),
    .dout_valid (dout_valid),
    .sp         (sp),
    .empty      (empty),
    .full       (full),
    .err        (err)
`ifdef STACK_PEEK_EN
    ,
    .top        (top)
`endif
  );

  // ---------------- clock / reset block ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [DATA_W-1:0] exp_q[$];    // model stack, back = top
  logic [DATA_W-1:0] got_q[$];    // dout values seen with dout_valid
  logic [DATA_W-1:0] exp_dout;
  logic              exp_valid;
  logic              exp_err;
  logic              model_ok;
  int                n_cmp;
  int                n_bad;

  initial begin
    model_ok  = 1'b0;
    n_cmp     = 0;
    n_bad     = 0;
    exp_dout  = '0;
    exp_valid = 1'b0;
    exp_err   = 1'b0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model of one clock edge, from the stack's documented rules.
  task automatic model_apply(input logic c, input logic p, input logic q, input logic [DATA_W-1:0] d);
    if (!c) begin
      exp_q.delete();
      exp_dout  = '0;
      exp_valid = 1'b0;
      exp_err   = 1'b0;
    end else if (p && q) begin
      exp_valid = 1'b1;
      if (exp_q.size() == 0) begin
        exp_dout = d;
      end else begin
        exp_dout = exp_q[$];
        exp_q[exp_q.size()-1] = d;
      end
    end else if (p) begin
      exp_valid = 1'b0;
      if (exp_q.size() == DEPTH) exp_err = 1'b1;
      else exp_q.push_back(d);
    end else if (q) begin
      if (exp_q.size() == 0) begin
        exp_err   = 1'b1;
        exp_valid = 1'b0;
      end else begin
        exp_dout  = exp_q.pop_back();
        exp_valid = 1'b1;
      end
    end else begin
      exp_valid = 1'b0;
    end
    if (!c) model_ok = 1'b1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input logic c, input logic p, input logic q, input logic [DATA_W-1:0] d);
    clr  = c;
    push = p;
    pop  = q;
    din  = d;
    @(posedge clk);
    model_apply(c, p, q, d);
    #1;
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b0, '0);
    step(1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic do_push(input logic [DATA_W-1:0] d);
    step(1'b1, 1'b1, 1'b0, d);
  endtask

  task automatic do_pop();
    step(1'b1, 1'b0, 1'b1, '0);
  endtask

  task automatic do_idle();
    step(1'b1, 1'b0, 1'b0, '0);
  endtask

  // ---------------- compare process (every cycle, away from the edge) ----------------
  always @(negedge clk) begin
    if (model_ok) begin
      check("sp", 32'(sp), 32'(exp_q.size()));
      check("empty", 32'(empty), 32'(exp_q.size() == 0));
      check("full", 32'(full), 32'(exp_q.size() == DEPTH));
      check("err", 32'(err), 32'(exp_err));
      check("dout_valid", 32'(dout_valid), 32'(exp_valid));
      check("dout", 32'(dout), 32'(exp_dout));
`ifdef STACK_PEEK_EN
      check("top", 32'(top), (exp_q.size() == 0) ? 32'd0 : 32'(exp_q[$]));
`endif
      if (dout_valid) got_q.push_back(dout);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    clr  = 1'b0;
    push = 1'b0;
    pop  = 1'b0;
    din  = '0;

    // 1: reset then idle
    do_reset();
    do_idle();
    check("t1_sp", 32'(sp), 32'd0);
    check("t1_empty", 32'(empty), 32'd1);
    check("t1_full", 32'(full), 32'd0);
    check("t1_err", 32'(err), 32'd0);
    check("t1_dout", 32'(dout), 32'd0);
    check("t1_valid", 32'(dout_valid), 32'd0);

    // 2: push 1,1,2,3,5 then pop five times
    got_q.delete();
    do_push(16'd1); do_push(16'd1); do_push(16'd2); do_push(16'd3); do_push(16'd5);
    check("t2_sp_peak", 32'(sp), 32'd5);
    do_pop();
    check("t2_first_pop_dout", 32'(dout), 32'd5);
    check("t2_first_pop_valid", 32'(dout_valid), 32'd1);
    for (int i = 0; i < 4; i++) do_pop();
    do_idle();
    check("t2_n_valid", 32'(got_q.size()), 32'd5);
    if (got_q.size() == 5) begin
      check("t2_seq0", 32'(got_q[0]), 32'd5);
      check("t2_seq1", 32'(got_q[1]), 32'd3);
      check("t2_seq2", 32'(got_q[2]), 32'd2);
      check("t2_seq3", 32'(got_q[3]), 32'd1);
      check("t2_seq4", 32'(got_q[4]), 32'd1);
    end
    check("t2_sp_end", 32'(sp), 32'd0);
    check("t2_empty", 32'(empty), 32'd1);
    check("t2_err", 32'(err), 32'd0);

    // 3: fill, overflow, pop returns last real entry
    do_reset();
    for (int i = 0; i < DEPTH; i++) do_push(DATA_W'(i));
    check("t3_full", 32'(full), 32'd1);
    check("t3_sp", 32'(sp), 32'd32);
    check("t3_err_before", 32'(err), 32'd0);
    do_push(16'd99);
    check("t3_err", 32'(err), 32'd1);
    check("t3_sp_after", 32'(sp), 32'd32);
    do_pop();
    check("t3_pop_dout", 32'(dout), 32'd31);
    check("t3_pop_valid", 32'(dout_valid), 32'd1);

    // 4: underflow, then err stays sticky
    do_reset();
    do_pop();
    check("t4_err", 32'(err), 32'd1);
    check("t4_valid", 32'(dout_valid), 32'd0);
    check("t4_sp", 32'(sp), 32'd0);
    do_push(16'd7);
    do_pop();
    check("t4_dout", 32'(dout), 32'd7);
    check("t4_valid2", 32'(dout_valid), 32'd1);
    check("t4_err_sticky", 32'(err), 32'd1);

    // 5: replace top, and bypass on empty
    do_reset();
    do_push(16'd8);
    do_push(16'd13);
    step(1'b1, 1'b1, 1'b1, 16'd21);
    check("t5_rep_dout", 32'(dout), 32'd13);
    check("t5_rep_valid", 32'(dout_valid), 32'd1);
    check("t5_rep_sp", 32'(sp), 32'd2);
    do_pop();
    check("t5_pop_dout", 32'(dout), 32'd21);
    do_reset();
    step(1'b1, 1'b1, 1'b1, 16'd4);
    check("t5_byp_dout", 32'(dout), 32'd4);
    check("t5_byp_sp", 32'(sp), 32'd0);
    check("t5_byp_err", 32'(err), 32'd0);
    check("t5_byp_valid", 32'(dout_valid), 32'd1);

    // 6: reset wins over a pending pop
    do_reset();
    do_push(16'd1); do_push(16'd2); do_push(16'd3);
    step(1'b0, 1'b0, 1'b1, '0);
    check("t6_sp", 32'(sp), 32'd0);
    check("t6_valid", 32'(dout_valid), 32'd0);
    check("t6_dout", 32'(dout), 32'd0);
`ifdef STACK_PEEK_EN
    do_push(16'd34);
    check("t6_top", 32'(top), 32'd34);
    do_reset();
    check("t6_top_reset", 32'(top), 32'd0);
`endif

    // Randomized phase: biased push/pop mix per epoch, rare resets.
    do_reset();
    for (int e = 0; e < 20; e++) begin
      int bias;
      bias = $urandom_range(10, 90);
      for (int i = 0; i < 150; i++) begin
        logic c, p, q;
        c = ($urandom_range(0, 199) != 0);
        p = ($urandom_range(0, 99) < bias);
        q = ($urandom_range(0, 99) >= bias) || ($urandom_range(0, 9) == 0);
        step(c, p, q, DATA_W'($urandom));
      end
    end
    do_idle();
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
